pc_flag_unit: RTL and testbench
===============================

// Module: pc_flag_unit
// PURPOSE
//  Program-counter and status-flag stage directly downstream of the KGPRISC ALU.
//  - Latches the ALU carry/zero/overflow/sign flags into an architectural flag register.
//  - Resolves the eight branch instructions against the flags or a register value.
//  - Selects and registers the next PC, and produces the link address for bl.
//  - br_addr is the ALU DA sum (base + offset) or a decoded absolute label.
// PARAMETERS
//  PC_W      32     PC / address width.
//  RESET_PC  32'h0  PC value loaded on reset.
//  INSTR_B   4      Byte increment for sequential fetch.
// PORTS
//  clk        in   1     Rising-edge clock.
//  rst_n      in   1     Asynchronous, active-low reset.
//  pc_en      in   1     Retire/advance; 0 = stall, all state held.
//  flag_we    in   1     Current instruction writes flags; qualified by pc_en.
//  carry_in   in   1     ALU carryflag.
//  zero_in    in   1     ALU zflag.
//  ovf_in     in   1     ALU overflowflag.
//  sign_in    in   1     ALU signflag.
//  br_valid   in   1     Current instruction is a branch.
//  br_op      in   3     Branch type (see BEHAVIOUR).
//  rs_val     in   PC_W  Register operand for br/bltz/bz/bnz.
//  br_addr    in   PC_W  Label target (ALU DA or decoded absolute address).
//  pc         out  PC_W  Current PC (registered).
//  link_addr  out  PC_W  pc+INSTR_B (combinational).
//  link_we    out  1     1 when pc_en & br_valid & br_op==bl (combinational).
//  flags      out  4     {C,Z,V,S} (registered).
//  br_taken   out  1     Registered pulse: a branch was taken at the previous edge.
// BEHAVIOUR
//  - Reset (async assert, sync release): pc=RESET_PC, flags=4'b0, br_taken=0.
//    Reset mid-stall or mid-branch discards the pending redirect.
//  - br_op encoding and taken condition:
//    000 br   : always, target = rs_val
//    001 bltz : rs_val[31]
//    010 bz   : rs_val == 0
//    011 bnz  : rs_val != 0
//    100 b    : always
//    101 bl   : always
//    110 bcy  : flags.C
//    111 bncy : !flags.C
//    All other ops take target = br_addr.
//  - Target alignment: bits [1:0] of the target are forced to 0.
//  - Next PC at the clock edge when pc_en=1:
//    taken = br_valid & cond; pc <= taken ? target : pc+INSTR_B.
//    Addition wraps modulo 2^PC_W (e.g. 32'hFFFF_FFFC -> 0).
//  - Flags: if pc_en & flag_we, then flags <= {carry_in,zero_in,ovf_in,sign_in}.
//    Same-cycle flag_we and bcy/bncy: the branch evaluates the pre-update flags.
//  - br_taken <= pc_en & taken. When pc_en=0, br_taken <= 0.
//  - pc_en=0: pc and flags hold. link_we forced 0.
//  - br_valid=0: br_op, rs_val and br_addr are ignored.
//  - Latency: redirect visible on pc one cycle after the branch edge; no delay slot.
// CONFIGURATION
//  KGP_BRANCH_COUNT_EN defined: adds output br_count [31:0].
//   - Counts taken branches. Increments at the same edge br_taken is set.
//   - Saturates at 32'hFFFF_FFFF. Reset value 0.
//  Undefined: port and counter are absent; all other behaviour is identical.
// TESTING
//  1. Reset: rst_n=0 with RESET_PC=32'h100, then release, pc_en=1 for 3 cycles.
//     -> pc=100,104,108,10C; flags=0; br_taken=0.
//  2. Flag-gated branch: flag_we=1, carry_in=1, then bcy with br_addr=32'h40.
//     -> pc=40, br_taken=1 for one cycle.
//     Repeat with carry_in=0 -> pc advances by 4.
//  3. Same-cycle flag write: flags.C=0, then in one cycle flag_we=1, carry_in=1 and bncy to 32'h80.
//     -> branch taken to 80; flags.C=1 afterward.
//  4. Register branches: bz with rs_val=0 -> taken.
//     bnz with rs_val=5 -> taken.
//     bltz with rs_val=32'h8000_0000 -> taken.
//     br with rs_val=32'h203 -> pc=200.
//  5. bl at pc=32'h20 to 32'h300 -> link_we=1, link_addr=24, next pc=300.
//     Stall (pc_en=0) for 2 cycles -> pc, flags held; link_we=0.
//  6. Wrap: pc=32'hFFFF_FFFC, no branch -> pc=0.
//     Assert rst_n low mid-cycle -> pc=RESET_PC immediately.
//     With KGP_BRANCH_COUNT_EN: br_count equals the number of taken branches in the run.

Source files
------------

// File: rtl/pc_flag_unit.sv
// PC and status-flag stage behind the KGPRISC ALU: flag register, branch resolution, next-PC select.
// Optional taken-branch counter on br_count when KGP_BRANCH_COUNT_EN is defined.
module pc_flag_unit #(
    parameter int unsigned     PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int unsigned     INSTR_B  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pc_en,
    input  logic            flag_we,
    input  logic            carry_in,
    input  logic            zero_in,
    input  logic            ovf_in,
    input  logic            sign_in,
    input  logic            br_valid,
    input  logic [2:0]      br_op,
    input  logic [PC_W-1:0] rs_val,
    input  logic [PC_W-1:0] br_addr,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] link_addr,
    output logic            link_we,
    output logic [3:0]      flags,
`ifdef KGP_BRANCH_COUNT_EN
    output logic [31:0]     br_count,
`endif
    output logic            br_taken
);

    localparam logic [2:0] OP_BR   = 3'b000;
    localparam logic [2:0] OP_BLTZ = 3'b001;
    localparam logic [2:0] OP_BZ   = 3'b010;
    localparam logic [2:0] OP_BNZ  = 3'b011;
    localparam logic [2:0] OP_B    = 3'b100;
    localparam logic [2:0] OP_BL   = 3'b101;
    localparam logic [2:0] OP_BCY  = 3'b110;
    localparam logic [2:0] OP_BNCY = 3'b111;

    localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);

    logic            cond;
    logic            taken;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] pc_next;

    // Branch condition uses the registered (pre-update) carry flag.
    always_comb begin
        cond = 1'b0;
        case (br_op)
            OP_BR:   cond = 1'b1;
            OP_BLTZ: cond = rs_val[PC_W-1];
            OP_BZ:   cond = (rs_val == '0);
            OP_BNZ:  cond = (rs_val != '0);
            OP_B:    cond = 1'b1;
            OP_BL:   cond = 1'b1;
            OP_BCY:  cond = flags[3];
            OP_BNCY: cond = ~flags[3];
            default: cond = 1'b0;
        endcase
    end

    always_comb begin
        target    = ((br_op == OP_BR) ? rs_val : br_addr) & ALIGN_MASK;
        taken     = br_valid & cond;
        link_addr = pc + PC_W'(INSTR_B);
        link_we   = pc_en & br_valid & (br_op == OP_BL);
        pc_next   = taken ? target : link_addr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            flags    <= 4'b0;
            br_taken <= 1'b0;
        end else begin
            br_taken <= pc_en & taken;
            if (pc_en) begin
                pc <= pc_next;
                if (flag_we) flags <= {carry_in, zero_in, ovf_in, sign_in};
            end
        end
    end

`ifdef KGP_BRANCH_COUNT_EN
    // Saturating count of taken branches, updated on the same edge as br_taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count <= 32'h0;
        end else if (pc_en && taken && (br_count != 32'hFFFF_FFFF)) begin
            br_count <= br_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_flag_unit.sv
// Directed vector bench for pc_flag_unit with RESET_PC=32'h100.
module tb_pc_flag_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_en, flag_we, carry_in, zero_in, ovf_in, sign_in, br_valid;
    logic [2:0]  br_op;
    logic [31:0] rs_val, br_addr;
    logic [31:0] pc, link_addr;
    logic        link_we, br_taken;
    logic [3:0]  flags;
`ifdef KGP_BRANCH_COUNT_EN
    logic [31:0] br_count;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    pc_flag_unit #(.PC_W(32), .RESET_PC(32'h100), .INSTR_B(4)) dut (
        .clk(clk), .rst_n(rst_n), .pc_en(pc_en), .flag_we(flag_we),
        .carry_in(carry_in), .zero_in(zero_in), .ovf_in(ovf_in), .sign_in(sign_in),
        .br_valid(br_valid), .br_op(br_op), .rs_val(rs_val), .br_addr(br_addr),
        .pc(pc), .link_addr(link_addr), .link_we(link_we), .flags(flags),
`ifdef KGP_BRANCH_COUNT_EN
        .br_count(br_count),
`endif
        .br_taken(br_taken)
    );

    typedef struct {
        logic        en;
        logic        fwe;
        logic [3:0]  fl;
        logic        bv;
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] addr;
        logic        e_lwe;
        logic [31:0] e_link;
        logic [31:0] e_pc;
        logic [3:0]  e_flags;
        logic        e_tk;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic en, logic fwe, logic [3:0] fl, logic bv, logic [2:0] op,
                                logic [31:0] rs, logic [31:0] addr, logic e_lwe,
                                logic [31:0] e_link, logic [31:0] e_pc, logic [3:0] e_flags,
                                logic e_tk);
        vec_t v;
        v.en = en; v.fwe = fwe; v.fl = fl; v.bv = bv; v.op = op; v.rs = rs; v.addr = addr;
        v.e_lwe = e_lwe; v.e_link = e_link; v.e_pc = e_pc; v.e_flags = e_flags; v.e_tk = e_tk;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        pc_en    = v.en;
        flag_we  = v.fwe;
        {carry_in, zero_in, ovf_in, sign_in} = v.fl;
        br_valid = v.bv;
        br_op    = v.op;
        rs_val   = v.rs;
        br_addr  = v.addr;
    endtask

    int exp_taken_cnt = 0;

    initial begin
        //      en fwe fl    bv op    rs             addr           lwe link           pc             flags tk
        vecs.push_back(mk(1, 0, 4'h0, 0, 3'd0, 32'h0,        32'h0,        0, 32'h104,      32'h104,      4'h0, 0));
        vecs.push_back(mk(1, 0, 4'h0, 0, 3'd0, 32'h0,        32'h0,        0, 32'h108,      32'h108,      4'h0, 0));
        vecs.push_back(mk(1, 0, 4'h0, 0, 3'd0, 32'h0,        32'h0,        0, 32'h10C,      32'h10C,      4'h0, 0));
        vecs.push_back(mk(1, 1, 4'h8, 0, 3'd0, 32'h0,        32'h0,        0, 32'h110,      32'h110,      4'h8, 0));
        vecs.push_back(mk(1, 0, 4'h0, 1, 3'd6, 32'h0,        32'h40,       0, 32'h114,      32'h40,       4'h8, 1));
        vecs.push_back(mk(1, 0, 4'h0, 0, 3'd0, 32'h0,        32'h0,        0, 32'h44,       32'h44,       4'h8, 0));
        vecs.push_back(mk(1, 1, 4'h4, 0, 3'd0, 32'h0,        32'h0,        0, 32'h48,       32'h48,       4'h4, 0));
        vecs.push_back(mk(1, 0, 4'h0, 1, 3'd6, 32'h0,        32'h40,       0, 32'h4C,       32'h4C,       4'h4, 0));
        vecs.push_back(mk(1, 1, 4'h8, 1, 3'd7, 32'h0,        32'h80,       0, 32'h50,       32'h80,       4'h8, 1));
        vecs.push_back(mk(1, 0, 4'h0, 1, 3'd2, 32'h0,        32'h90,       0, 32'h84,       32'h90,       4'h8, 1));
        vecs.push_back(mk(1, 0, 4'h0, 1, 3'd3, 32'h5,        32'hA0,       0, 32'h94,       32'hA0,       4'h8, 1));
        vecs.push_back(mk(1, 0, 4'h0, 1, 3'd1, 32'h8000_0000, 32'hB0,      0, 32'hA4,       32'hB0,       4'h8, 1));
        vecs.push_back(mk(1, 0, 4'h0, 1, 3'd1, 32'h7FFF_FFFF, 32'hC0,      0, 32'hB4,       32'hB4,       4'h8, 0));
        vecs.push_back(mk(1, 0, 4'h0, 1, 3'd0, 32'h203,      32'h0,        0, 32'hB8,       32'h200,      4'h8, 1));
        vecs.push_back(mk(1, 0, 4'h0, 1, 3'd2, 32'h1,        32'h300,      0, 32'h204,      32'h204,      4'h8, 0));
        vecs.push_back(mk(1, 0, 4'h0, 0, 3'd4, 32'h0,        32'h300,      0, 32'h208,      32'h208,      4'h8, 0));
        vecs.push_back(mk(1, 0, 4'h0, 1, 3'd4, 32'h0,        32'h21,       0, 32'h20C,      32'h20,       4'h8, 1));
        vecs.push_back(mk(1, 0, 4'h0, 1, 3'd5, 32'h0,        32'h300,      1, 32'h24,       32'h300,      4'h8, 1));
        vecs.push_back(mk(0, 1, 4'h7, 1, 3'd5, 32'h0,        32'h500,      0, 32'h304,      32'h300,      4'h8, 0));
        vecs.push_back(mk(0, 0, 4'h0, 0, 3'd0, 32'h0,        32'h0,        0, 32'h304,      32'h300,      4'h8, 0));
        vecs.push_back(mk(1, 1, 4'h3, 1, 3'd4, 32'h0,        32'h304,      0, 32'h304,      32'h304,      4'h3, 1));
        vecs.push_back(mk(1, 0, 4'h0, 1, 3'd4, 32'h0,        32'hFFFF_FFFF, 0, 32'h308,     32'hFFFF_FFFC, 4'h3, 1));
        vecs.push_back(mk(1, 0, 4'h0, 0, 3'd0, 32'h0,        32'h0,        0, 32'h0,        32'h0,        4'h3, 0));
        vecs.push_back(mk(1, 0, 4'h0, 1, 3'd7, 32'h0,        32'h10,       0, 32'h4,        32'h10,       4'h3, 1));
        vecs.push_back(mk(0, 0, 4'h0, 0, 3'd0, 32'h0,        32'h0,        0, 32'h14,       32'h10,       4'h3, 0));

        drive(mk(0, 0, 4'h0, 0, 3'd0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 4'h0, 0));
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset pc", pc, 32'h100);
        chk("reset flags", 32'(flags), 32'h0);
        chk("reset br_taken", 32'(br_taken), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d link_we", i), 32'(link_we), 32'(vecs[i].e_lwe));
            chk($sformatf("v%0d link_addr", i), link_addr, vecs[i].e_link);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d pc", i), pc, vecs[i].e_pc);
            chk($sformatf("v%0d flags", i), 32'(flags), 32'(vecs[i].e_flags));
            chk($sformatf("v%0d br_taken", i), 32'(br_taken), 32'(vecs[i].e_tk));
            if (vecs[i].e_tk) exp_taken_cnt++;
            @(negedge clk);
        end

`ifdef KGP_BRANCH_COUNT_EN
        chk("br_count", br_count, 32'(exp_taken_cnt));
`endif

        // Mid-cycle reset while a taken branch is pending discards the redirect.
        drive(mk(1, 1, 4'hF, 1, 3'd4, 32'h0, 32'h400, 0, 32'h0, 32'h0, 4'h0, 0));
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst pc", pc, 32'h100);
        chk("midrst flags", 32'(flags), 32'h0);
        @(posedge clk);
        #1;
        chk("midrst hold pc", pc, 32'h100);
        chk("midrst br_taken", 32'(br_taken), 32'h0);
`ifdef KGP_BRANCH_COUNT_EN
        chk("midrst br_count", br_count, 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        drive(mk(1, 0, 4'h0, 0, 3'd0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 4'h0, 0));
        @(posedge clk);
        #1;
        chk("post-rst pc", pc, 32'h104);
        chk("post-rst br_taken", 32'(br_taken), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
